cb_nway: RTL and testbench
==========================

# cb_nway

Clocked, parametrised N-way branch for the elastic packet pipeline. It accepts one packet per cycle on a Send/Ack input channel and holds it in a single output slot. It then steers the packet to one of NOUT Send/Ack output channels, chosen by a branch field sampled at the moment of acceptance. This block supersedes the two-way self-timed branch in B_Stage wherever the stage runs from a common clock.

## Interface
- DW, 32, packet data width (≥1)
- NOUT, 2, number of output channels (2..16)
- SELW, $clog2(NOUT), branch field width (derived, not overridden)

- CLK  in  1  stage clock; all state updates on rising edge
- MR  in  1  master reset, synchronous, active-high
- Send_in  in  1  upstream packet valid
- Data_in  in  DW  upstream packet
- br  in  SELW  branch select, sampled with the packet
- Ack_out  out  1  upstream ready; transfer when Send_in & Ack_out at edge
- Send_out  out  NOUT  per-channel valid
- Data_out  out  DW  slot data, shared by all channels
- Ack_in  in  NOUT  per-channel downstream ready
- CP  out  1  acceptance strobe, Send_in & Ack_out, combinational
- Err  out  1  sticky flag: packet accepted with br ≥ NOUT
- Bc  in  1  broadcast request, sampled with the packet (present only with CB_BCAST_EN)

## Operation
- State: slot data register, pending mask pend[NOUT], sticky Err. The slot is full exactly when pend ≠ 0.
- Send_out = pend. Data_out = slot data, valid whenever any Send_out bit is high.
- Per-channel completion: done[i] = pend[i] & Ack_in[i]. Next pend = pend & ~done, unless a new packet loads that cycle.
- Slot frees this cycle when (pend & ~done) == 0.
- Ack_out = ~MR & slot-frees-this-cycle. This covers the empty slot and the last pending channel completing, so the block sustains back-to-back packets at full throughput.
- On acceptance:
  - Data_in loads into the slot.
  - pend loads the one-hot mask of br.
  - If br ≥ NOUT, pend loads 0: the packet is consumed and dropped, Err is set, and no Send_out rises.
- Ack_in on a channel whose pend bit is 0 is ignored.
- Data_out and pend never change while any pend bit remains set, except through done clearing bits.
- MR has priority over everything: pend=0, slot data=0, Err=0, Ack_out=0, CP=0.

## Timing
- Latency: packet accepted at edge k appears on Send_out/Data_out from k+1.
- Minimum occupancy is 1 cycle when the target Ack_in is high at edge k+1.
- Outputs are held stable until acknowledged; Send_out never drops without a matching Ack_in.
- Simultaneous completion and acceptance at the same edge: the new packet replaces the slot with no bubble.
- Ack_in is combinationally fed into Ack_out; there is no combinational path from Send_in to Send_out.
- Reset values: Send_out=0, Data_out=0, Ack_out=0, CP=0, Err=0.
- Ack_out rises in the first cycle after MR deasserts.
- MR asserted mid-packet discards the packet. Downstream must not count an Ack at that edge as a transfer.

## Configuration
- CB_BCAST_EN defined:
  - Bc port exists.
  - Acceptance with Bc=1 loads pend = all ones, ignoring br and never setting Err.
  - Each channel completes independently. The slot frees, and Ack_out rises, in the cycle the last outstanding channel acks.
- CB_BCAST_EN undefined: no Bc port; unicast only. Logic is otherwise identical.

## Structure
- Shared package cb_pkg:
  - function cb_selw(n) returning the branch width.
  - function cb_onehot(sel, n) returning the mask, 0 when out of range.
  - typedef for the pend mask at the maximum NOUT.
- Sub-module cb_slot holds the data register, the pend mask update and the free logic.
- cb_nway adds decode, Err, CP and the broadcast selection.

## Test plan
- Reset:
  - Hold MR for 3 cycles while Send_in=1.
  - Required: all outputs 0 throughout and no acceptance.
  - Ack_out=1 on the first cycle after release.
- Unicast streaming:
  - NOUT=4, Ack_in=4'b1111, packets 0x11,0x22,0x33 with br=2,0,3 on consecutive cycles.
  - Required: Send_out = 0100, 0001, 1000 on consecutive cycles with matching Data_out. CP high 3 cycles.
- Backpressure:
  - Packet 0xAA with br=1 while Ack_in[1]=0 for 4 cycles, with a second packet waiting.
  - Required: Send_out=0010 and Data_out=0xAA stable, and Ack_out=0.
  - When Ack_in[1] rises, the second packet loads at that same edge.
- Out-of-range select:
  - NOUT=3, br=3, packet 0x5.
  - Required: CP=1, Send_out stays 000, and Err=1 until MR.
- Broadcast (CB_BCAST_EN):
  - NOUT=4, Bc=1, Ack_in bits rise on cycles 1, 3, 3 and 6.
  - Required: pend shrinks 1111→1110→1000→0000. Ack_out is high only in cycle 6.
- Reset mid-packet:
  - MR pulse while Send_out=0100.
  - Required: Send_out=0 on the next cycle. The old data never reappears.

Source files
------------

// File: rtl/cb_pkg.sv
// Shared types and helpers for the cb_nway N-way branch: branch-width
// derivation and one-hot decode of the branch select into a pending mask.
package cb_pkg;

    localparam int CB_NOUT_MAX = 16;

    typedef logic [CB_NOUT_MAX-1:0] cb_mask_t;

    function automatic int cb_selw(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Out-of-range selects decode to an empty mask so the packet is dropped.
    function automatic cb_mask_t cb_onehot(input int sel, input int n);
        cb_mask_t m;
        m = '0;
        if (sel >= 0 && sel < n) m = cb_mask_t'(1) << sel;
        return m;
    endfunction

endpackage

// File: rtl/cb_slot.sv
// Single-entry output slot for cb_nway: packet data, per-channel pending mask
// and the "slot frees this cycle" term that drives upstream Ack_out.
module cb_slot #(
    parameter int DW   = 32,
    parameter int NOUT = 2
) (
    input  logic            CLK,
    input  logic            MR,
    input  logic            i_load,
    input  logic [DW-1:0]   i_data,
    input  logic [NOUT-1:0] i_mask,
    input  logic [NOUT-1:0] i_ack,
    output logic [NOUT-1:0] o_pend,
    output logic [DW-1:0]   o_data,
    output logic            o_free
);

    logic [NOUT-1:0] r_pend;
    logic [DW-1:0]   r_data;
    logic [NOUT-1:0] w_rem;

    // Acks on channels that are not pending fall out of this mask naturally.
    assign w_rem  = r_pend & ~i_ack;
    assign o_free = (w_rem == '0);
    assign o_pend = r_pend;
    assign o_data = r_data;

    always_ff @(posedge CLK) begin
        if (MR) begin
            r_pend <= '0;
            r_data <= '0;
        end else if (i_load) begin
            r_pend <= i_mask;
            r_data <= i_data;
        end else begin
            r_pend <= w_rem;
        end
    end

endmodule

// File: rtl/cb_nway.sv
// Clocked N-way branch: accepts a packet into one slot and steers it to the
// channel chosen by br. Optional broadcast (Bc port) enabled by CB_BCAST_EN.
module cb_nway
    import cb_pkg::*;
#(
    parameter  int DW   = 32,
    parameter  int NOUT = 2,
    localparam int SELW = cb_selw(NOUT)
) (
    input  logic            CLK,
    input  logic            MR,
    input  logic            Send_in,
    input  logic [DW-1:0]   Data_in,
    input  logic [SELW-1:0] br,
    output logic            Ack_out,
    output logic [NOUT-1:0] Send_out,
    output logic [DW-1:0]   Data_out,
    input  logic [NOUT-1:0] Ack_in,
`ifdef CB_BCAST_EN
    input  logic            Bc,
`endif
    output logic            CP,
    output logic            Err
);

    cb_mask_t        w_full;
    logic [NOUT-1:0] w_uni;
    logic [NOUT-1:0] w_mask;
    logic            w_oor;
    logic            w_bc;
    logic            w_free;
    logic            r_err;

    assign w_full = cb_onehot(int'(br), NOUT);
    assign w_uni  = w_full[NOUT-1:0];
    assign w_oor  = (w_full == '0);

`ifdef CB_BCAST_EN
    assign w_bc = Bc;
`else
    assign w_bc = 1'b0;
`endif

    assign w_mask  = w_bc ? {NOUT{1'b1}} : w_uni;
    assign Ack_out = ~MR & w_free;
    assign CP      = Send_in & Ack_out;
    assign Err     = r_err;

    cb_slot #(
        .DW   (DW),
        .NOUT (NOUT)
    ) u_slot (
        .CLK    (CLK),
        .MR     (MR),
        .i_load (CP),
        .i_data (Data_in),
        .i_mask (w_mask),
        .i_ack  (Ack_in),
        .o_pend (Send_out),
        .o_data (Data_out),
        .o_free (w_free)
    );

    // A broadcast never counts as out of range, whatever br holds.
    always_ff @(posedge CLK) begin
        if (MR) begin
            r_err <= 1'b0;
        end else if (CP && !w_bc && w_oor) begin
            r_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_cb_nway.sv
// Bench for cb_nway: a 4-way and a 3-way instance, scoreboard of expected
// slot contents; broadcast scenario built only with CB_BCAST_EN.
module tb_cb_nway;

    typedef struct packed {
        logic [31:0] d;
        logic [3:0]  m;
    } exp_t;

    exp_t q[$];
    int   n_vec = 0;
    int   n_err = 0;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic        MR;
    logic        send4, ack4, cp4, err4;
    logic [31:0] data4, dout4;
    logic [1:0]  br4;
    logic [3:0]  ackin4, sout4;
    logic        send3, ack3, cp3, err3;
    logic [31:0] data3, dout3;
    logic [1:0]  br3;
    logic [2:0]  ackin3, sout3;
`ifdef CB_BCAST_EN
    logic        bc4, bc3;
`endif

    cb_nway #(.DW(32), .NOUT(4)) u4 (
        .CLK      (CLK),
        .MR       (MR),
        .Send_in  (send4),
        .Data_in  (data4),
        .br       (br4),
        .Ack_out  (ack4),
        .Send_out (sout4),
        .Data_out (dout4),
        .Ack_in   (ackin4),
`ifdef CB_BCAST_EN
        .Bc       (bc4),
`endif
        .CP       (cp4),
        .Err      (err4)
    );

    cb_nway #(.DW(32), .NOUT(3)) u3 (
        .CLK      (CLK),
        .MR       (MR),
        .Send_in  (send3),
        .Data_in  (data3),
        .br       (br3),
        .Ack_out  (ack3),
        .Send_out (sout3),
        .Data_out (dout3),
        .Ack_in   (ackin3),
`ifdef CB_BCAST_EN
        .Bc       (bc3),
`endif
        .CP       (cp3),
        .Err      (err3)
    );

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        MR = 1'b1; send4 = 1'b1; data4 = 32'h99; br4 = 2'd1; ackin4 = 4'hF;
        send3 = 1'b1; data3 = 32'h7; br3 = 2'd0; ackin3 = 3'h7;
        tick();
        for (int c = 0; c < 3; c++) begin
            #1;
            n_vec++;
            if ({sout4, dout4, ack4, cp4, err4, sout3, dout3, ack3, cp3, err3} !== '0) begin
                n_err++;
                $display("FAIL reset_hold c%0d: u4 send=%b data=%h ack=%b cp=%b err=%b u3 send=%b data=%h ack=%b cp=%b err=%b, required all 0",
                         c, sout4, dout4, ack4, cp4, err4, sout3, dout3, ack3, cp3, err3);
            end
            tick();
        end
        MR = 1'b0; send4 = 1'b0; send3 = 1'b0;
        #1;
        n_vec++;
        if ({ack4, ack3} !== 2'b11) begin
            n_err++;
            $display("FAIL reset_release: Ack_out u4=%b u3=%b, required 1 1", ack4, ack3);
        end
        tick();
        n_vec++;
        if ({sout4, sout3} !== 7'b0) begin
            n_err++;
            $display("FAIL reset_no_accept: Send_out u4=%b u3=%b, required 0", sout4, sout3);
        end
    endtask

    task automatic test_unicast();
        logic [31:0] ud[3];
        logic [1:0]  ub[3];
        logic [3:0]  um[3];
        exp_t        e;
        int          ncp;
        ud = '{32'h11, 32'h22, 32'h33};
        ub = '{2'd2, 2'd0, 2'd3};
        um = '{4'b0100, 4'b0001, 4'b1000};
        ackin4 = 4'b1111;
        ncp = 0;
        for (int i = 0; i < 4; i++) begin
            if (i < 3) begin
                send4 = 1'b1; data4 = ud[i]; br4 = ub[i];
                e.d = ud[i]; e.m = um[i];
                q.push_back(e);
            end else begin
                send4 = 1'b0;
            end
            #1;
            if (cp4 === 1'b1) ncp++;
            if (i > 0) begin
                n_vec++;
                if (q.size() == 0) begin
                    n_err++;
                    $display("FAIL unicast_out%0d: scoreboard empty, got send=%b data=%h", i, sout4, dout4);
                end else begin
                    e = q.pop_front();
                    if ({sout4, dout4} !== {e.m, e.d}) begin
                        n_err++;
                        $display("FAIL unicast_out%0d: send=%b data=%h, required send=%b data=%h",
                                 i, sout4, dout4, e.m, e.d);
                    end
                end
            end
            tick();
        end
        n_vec++;
        if (ncp != 3) begin
            n_err++;
            $display("FAIL unicast_cp: CP high %0d cycles, required 3", ncp);
        end
        n_vec++;
        if (sout4 !== 4'b0) begin
            n_err++;
            $display("FAIL unicast_drain: send=%b, required 0000", sout4);
        end
    endtask

    task automatic test_backpressure();
        exp_t e;
        ackin4 = 4'b1101;
        send4 = 1'b1; data4 = 32'hAA; br4 = 2'd1;
        #1;
        n_vec++;
        if ({cp4, ack4} !== 2'b11) begin
            n_err++;
            $display("FAIL bp_accept: cp=%b ack=%b, required 1 1", cp4, ack4);
        end
        e.d = 32'hAA; e.m = 4'b0010;
        q.push_back(e);
        tick();
        data4 = 32'hBB; br4 = 2'd3;
        for (int c = 0; c < 4; c++) begin
            #1;
            n_vec++;
            if ({sout4, dout4, ack4, cp4} !== {4'b0010, 32'hAA, 1'b0, 1'b0}) begin
                n_err++;
                $display("FAIL bp_hold c%0d: send=%b data=%h ack=%b cp=%b, required 0010 aa 0 0",
                         c, sout4, dout4, ack4, cp4);
            end
            tick();
        end
        ackin4 = 4'b1111;
        #1;
        n_vec++;
        if (q.size() == 0) begin
            n_err++;
            $display("FAIL bp_release_out: scoreboard empty, got send=%b data=%h", sout4, dout4);
        end else begin
            e = q.pop_front();
            if ({sout4, dout4} !== {e.m, e.d}) begin
                n_err++;
                $display("FAIL bp_release_out: send=%b data=%h, required send=%b data=%h",
                         sout4, dout4, e.m, e.d);
            end
        end
        n_vec++;
        if ({ack4, cp4} !== 2'b11) begin
            n_err++;
            $display("FAIL bp_same_edge: ack=%b cp=%b, required 1 1", ack4, cp4);
        end
        e.d = 32'hBB; e.m = 4'b1000;
        q.push_back(e);
        tick();
        send4 = 1'b0;
        #1;
        n_vec++;
        if (q.size() == 0) begin
            n_err++;
            $display("FAIL bp_second_out: scoreboard empty, got send=%b data=%h", sout4, dout4);
        end else begin
            e = q.pop_front();
            if ({sout4, dout4} !== {e.m, e.d}) begin
                n_err++;
                $display("FAIL bp_second_out: send=%b data=%h, required send=%b data=%h",
                         sout4, dout4, e.m, e.d);
            end
        end
        tick();
        n_vec++;
        if ({sout4, err4} !== 5'b0) begin
            n_err++;
            $display("FAIL bp_drain: send=%b err=%b, required 0000 0", sout4, err4);
        end
    endtask

    task automatic test_oor();
        ackin3 = 3'b111;
        send3 = 1'b1; data3 = 32'h5; br3 = 2'd3;
        #1;
        n_vec++;
        if ({cp3, ack3} !== 2'b11) begin
            n_err++;
            $display("FAIL oor_accept: cp=%b ack=%b, required 1 1", cp3, ack3);
        end
        tick();
        send3 = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            n_vec++;
            if ({sout3, err3, ack3} !== {3'b000, 1'b1, 1'b1}) begin
                n_err++;
                $display("FAIL oor_drop c%0d: send=%b err=%b ack=%b, required 000 1 1", c, sout3, err3, ack3);
            end
            tick();
        end
        MR = 1'b1;
        tick();
        MR = 1'b0;
        #1;
        n_vec++;
        if ({err3, err4} !== 2'b00) begin
            n_err++;
            $display("FAIL oor_clear: err u3=%b u4=%b, required 0 0", err3, err4);
        end
        tick();
    endtask

    task automatic test_mid_reset();
        exp_t e;
        ackin4 = 4'b1011;
        send4 = 1'b1; data4 = 32'h77; br4 = 2'd2;
        e.d = 32'h77; e.m = 4'b0100;
        q.push_back(e);
        tick();
        send4 = 1'b0;
        #1;
        n_vec++;
        if (q.size() == 0) begin
            n_err++;
            $display("FAIL midrst_out: scoreboard empty, got send=%b data=%h", sout4, dout4);
        end else begin
            e = q.pop_front();
            if ({sout4, dout4} !== {e.m, e.d}) begin
                n_err++;
                $display("FAIL midrst_out: send=%b data=%h, required send=%b data=%h",
                         sout4, dout4, e.m, e.d);
            end
        end
        MR = 1'b1;
        tick();
        MR = 1'b0;
        ackin4 = 4'b1111;
        for (int c = 0; c < 3; c++) begin
            #1;
            n_vec++;
            if ({sout4, dout4, ack4} !== {4'b0, 32'h0, 1'b1}) begin
                n_err++;
                $display("FAIL midrst_gone c%0d: send=%b data=%h ack=%b, required 0000 0 1", c, sout4, dout4, ack4);
            end
            tick();
        end
    endtask

`ifdef CB_BCAST_EN
    task automatic test_broadcast();
        logic [3:0] acks[7];
        logic [3:0] pend[7];
        logic       aok[7];
        exp_t       e;
        acks = '{4'b0000, 4'b0001, 4'b0001, 4'b0111, 4'b0111, 4'b0111, 4'b1111};
        pend = '{4'b0000, 4'b1111, 4'b1110, 4'b1110, 4'b1000, 4'b1000, 4'b1000};
        aok  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        ackin4 = 4'b0000;
        send4 = 1'b1; bc4 = 1'b1; data4 = 32'hC3; br4 = 2'd3;
        e.d = 32'hC3; e.m = 4'b1111;
        q.push_back(e);
        tick();
        send4 = 1'b0; bc4 = 1'b0;
        for (int c = 1; c < 7; c++) begin
            ackin4 = acks[c];
            #1;
            if (c == 1) begin
                n_vec++;
                if (q.size() == 0) begin
                    n_err++;
                    $display("FAIL bcast_out: scoreboard empty, got send=%b data=%h", sout4, dout4);
                end else begin
                    e = q.pop_front();
                    if ({sout4, dout4} !== {e.m, e.d}) begin
                        n_err++;
                        $display("FAIL bcast_out: send=%b data=%h, required send=%b data=%h",
                                 sout4, dout4, e.m, e.d);
                    end
                end
            end
            n_vec++;
            if ({sout4, dout4, ack4} !== {pend[c], 32'hC3, aok[c]}) begin
                n_err++;
                $display("FAIL bcast_c%0d: send=%b data=%h ack=%b, required %b c3 %b",
                         c, sout4, dout4, ack4, pend[c], aok[c]);
            end
            tick();
        end
        n_vec++;
        if ({sout4, err4} !== 5'b0) begin
            n_err++;
            $display("FAIL bcast_done: send=%b err=%b, required 0000 0", sout4, err4);
        end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, required finish");
        $fatal(1, "timeout");
    end

    initial begin
        MR = 1'b1;
        send4 = 1'b0; data4 = '0; br4 = '0; ackin4 = '0;
        send3 = 1'b0; data3 = '0; br3 = '0; ackin3 = '0;
`ifdef CB_BCAST_EN
        bc4 = 1'b0; bc3 = 1'b0;
`endif
        test_reset();
        test_unicast();
        test_backpressure();
        test_oor();
        test_mid_reset();
`ifdef CB_BCAST_EN
        test_broadcast();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
